// File: rtl/sdram_init_seq_pkg.sv
// sdram_pkg: shared SDRAM command encodings, mode-register bit positions,
// the init sequencer state type and the mode-word builder.
package sdram_pkg;

  // Command encoding {CS_N, RAS_N, CAS_N, WE_N}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_RD  = 4'b0101;
  localparam logic [3:0] CMD_WR  = 4'b0100;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  // Mode-register / address bit positions
  localparam int MR_BL_LSB = 0;   // A[2:0] burst length
  localparam int MR_BT     = 3;   // A3 burst type
  localparam int MR_CL_LSB = 4;   // A[6:4] CAS latency
  localparam int MR_WB     = 9;   // A9 write burst mode
  localparam int MR_A10    = 10;  // A10: precharge-all select

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_PWRUP    = 4'd1,
    S_PRE      = 4'd2,
    S_WAIT_RP  = 4'd3,
    S_REF      = 4'd4,
    S_WAIT_RFC = 4'd5,
    S_LMR      = 4'd6,
    S_WAIT_MRD = 4'd7,
    S_DONE     = 4'd8
  } init_state_t;

  // Mode word, 32 bits wide; callers slice to their address width.
  function automatic logic [31:0] mode_word(input logic [2:0] cas, input logic bt,
                                            input logic [2:0] bl, input logic wb);
    logic [31:0] m;
    m = '0;
    m[MR_CL_LSB +: 3] = cas;
    m[MR_BT]          = bt;
    m[MR_BL_LSB +: 3] = bl;
    m[MR_WB]          = wb;
    return m;
  endfunction

endpackage

// File: rtl/sdram_init_seq_if.sv
// sdram_init_seq_if: control handshake between the system controller and
// the init sequencer.
//   ireq  : start / restart initialisation
//   ienb  : SDRAM pin drive enable
//   ofin  : initialisation complete
//   obusy : sequence in progress
interface sdram_init_seq_if;
  logic ireq;
  logic ienb;
  logic ofin;
  logic obusy;

  modport master (output ireq, ienb, input  ofin, obusy);
  modport slave  (input  ireq, ienb, output ofin, obusy);
endinterface

// File: rtl/sdram_wait_timer.sv
// sdram_wait_timer: loadable down-counter shared by every wait of the init
// sequence. Holds at zero; o_done is high while the count is zero.
//   clk, rst : clock, synchronous active-high reset
//   i_load   : load i_value this cycle
//   i_value  : value to load
//   o_done   : count is zero
module sdram_wait_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_done
);
  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst)                r_cnt <= '0;
    else if (i_load)        r_cnt <= i_value;
    else if (r_cnt != '0)   r_cnt <= r_cnt - 1'b1;
  end

  assign o_done = (r_cnt == '0);
endmodule

// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDRAM power-up initialisation sequencer.
// Power-up NOP wait, PRECHARGE ALL, N_REFRESH auto-refreshes, LOAD MODE
// REGISTER, then DONE. A request in DONE re-runs the sequence.
// Ports:
//   iclk, ireset : clock, synchronous active-high reset
//   ctl          : handshake (ireq, ienb in; ofin, obusy out)
//   DRAM_*       : SDRAM pins, high-Z whenever ctl.ienb is low
module sdram_init_seq
  import sdram_pkg::*;
#(
  parameter int ADDR_W            = 13,
  parameter int BA_W              = 2,
  parameter int DQ_W              = 16,
  parameter int DQM_W             = 2,
  parameter int T_POWERUP         = 10000,
  parameter int T_RP              = 2,
  parameter int T_RFC             = 7,
  parameter int T_MRD             = 2,
  parameter int N_REFRESH         = 8,
  parameter int CAS_LAT           = 2,
  parameter int BURST_TYPE        = 0,
  parameter int BURST_LEN         = 0,
  parameter int WB_SINGLE         = 1,
  parameter int REINIT_SKIP_PWRUP = 1
) (
  input  logic              iclk,
  input  logic              ireset,
  sdram_init_seq_if.slave   ctl,
  output logic              DRAM_CLK,
  output logic              DRAM_CKE,
  output logic [ADDR_W-1:0] DRAM_ADDR,
  output logic [BA_W-1:0]   DRAM_BA,
  output logic              DRAM_CS_N,
  output logic              DRAM_RAS_N,
  output logic              DRAM_CAS_N,
  output logic              DRAM_WE_N,
  output logic              DRAM_LDQM,
  output logic              DRAM_UDQM,
  output logic [DQ_W-1:0]   DRAM_DQ
);
  localparam int TM1  = (T_POWERUP > T_RFC) ? T_POWERUP : T_RFC;
  localparam int TM2  = (T_RP > T_MRD) ? T_RP : T_MRD;
  localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
  localparam int TW   = (TMAX < 1) ? 1 : $clog2(TMAX + 1);
  localparam int RW   = $clog2(N_REFRESH + 1);

  // The timer is loaded on the edge that enters a state, so a gap of T
  // cycles needs T-1: the last cycle of the gap sees zero and issues the
  // next command on that same edge.
  localparam logic [TW-1:0] LD_PWR = TW'(T_POWERUP - 1);
  localparam logic [TW-1:0] LD_RP  = TW'(T_RP - 1);
  localparam logic [TW-1:0] LD_RFC = TW'(T_RFC - 1);
  localparam logic [TW-1:0] LD_MRD = TW'(T_MRD - 1);

  localparam logic [ADDR_W-1:0] A_PRE  = ADDR_W'(32'd1 << MR_A10);
  localparam logic [31:0]       MW     = mode_word(3'(CAS_LAT), 1'(BURST_TYPE),
                                                   3'(BURST_LEN), 1'(WB_SINGLE));
  localparam logic [ADDR_W-1:0] A_MODE = MW[ADDR_W-1:0];

  init_state_t       r_state, w_nxt;
  logic [3:0]        r_cmd, w_cmd;
  logic [ADDR_W-1:0] r_addr, w_addr;
  logic [BA_W-1:0]   r_ba;
  logic [DQM_W-1:0]  r_dqm;
  logic [RW-1:0]     r_ref_cnt;
  logic              w_ld, w_done, w_ref_inc, w_ref_clr;
  logic [TW-1:0]     w_ld_val;

  sdram_wait_timer #(.W(TW)) u_timer (
    .clk     (iclk),
    .rst     (ireset),
    .i_load  (w_ld),
    .i_value (w_ld_val),
    .o_done  (w_done)
  );

  // Next-state decode; its outputs are registered below, never driven to pins.
  always_comb begin
    w_nxt     = r_state;
    w_cmd     = CMD_NOP;
    w_addr    = '0;
    w_ld      = 1'b0;
    w_ld_val  = '0;
    w_ref_inc = 1'b0;
    w_ref_clr = 1'b0;
    case (r_state)
      S_IDLE: if (ctl.ireq) begin
        w_nxt = S_PWRUP; w_ld = 1'b1; w_ld_val = LD_PWR; w_ref_clr = 1'b1;
      end
      S_PWRUP: if (w_done) begin
        w_nxt = S_PRE; w_cmd = CMD_PRE; w_addr = A_PRE; w_ld = 1'b1; w_ld_val = LD_RP;
      end
      S_PRE, S_WAIT_RP: begin
        if (w_done) begin
          w_nxt = S_REF; w_cmd = CMD_REF; w_ld = 1'b1; w_ld_val = LD_RFC; w_ref_inc = 1'b1;
        end else begin
          w_nxt = S_WAIT_RP;
        end
      end
      S_REF, S_WAIT_RFC: begin
        if (w_done && (r_ref_cnt == RW'(N_REFRESH))) begin
          w_nxt = S_LMR; w_cmd = CMD_LMR; w_addr = A_MODE; w_ld = 1'b1; w_ld_val = LD_MRD;
        end else if (w_done) begin
          w_nxt = S_REF; w_cmd = CMD_REF; w_ld = 1'b1; w_ld_val = LD_RFC; w_ref_inc = 1'b1;
        end else begin
          w_nxt = S_WAIT_RFC;
        end
      end
      S_LMR, S_WAIT_MRD: w_nxt = w_done ? S_DONE : S_WAIT_MRD;
      S_DONE: if (ctl.ireq) begin
        w_ref_clr = 1'b1;
        w_ld      = 1'b1;
        if (REINIT_SKIP_PWRUP != 0) begin
          w_nxt = S_PRE; w_cmd = CMD_PRE; w_addr = A_PRE; w_ld_val = LD_RP;
        end else begin
          w_nxt = S_PWRUP; w_ld_val = LD_PWR;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      r_state   <= S_IDLE;
      r_cmd     <= CMD_NOP;
      r_addr    <= '0;
      r_ba      <= '0;
      r_dqm     <= '1;
      r_ref_cnt <= '0;
    end else begin
      r_state <= w_nxt;
      r_cmd   <= w_cmd;
      r_addr  <= w_addr;
      r_ba    <= '0;
      r_dqm   <= '1;
      if (w_ref_clr)      r_ref_cnt <= '0;
      else if (w_ref_inc) r_ref_cnt <= r_ref_cnt + 1'b1;
    end
  end

  assign ctl.ofin  = (r_state == S_DONE);
  assign ctl.obusy = (r_state != S_IDLE) && (r_state != S_DONE);

  // Pins only gate the registered values; the sequence runs regardless.
  assign DRAM_CLK   = ctl.ienb ? ~iclk          : 1'bz;
  assign DRAM_CKE   = ctl.ienb ? 1'b1           : 1'bz;
  assign DRAM_ADDR  = ctl.ienb ? r_addr         : {ADDR_W{1'bz}};
  assign DRAM_BA    = ctl.ienb ? r_ba           : {BA_W{1'bz}};
  assign DRAM_CS_N  = ctl.ienb ? r_cmd[3]       : 1'bz;
  assign DRAM_RAS_N = ctl.ienb ? r_cmd[2]       : 1'bz;
  assign DRAM_CAS_N = ctl.ienb ? r_cmd[1]       : 1'bz;
  assign DRAM_WE_N  = ctl.ienb ? r_cmd[0]       : 1'bz;
  assign DRAM_LDQM  = ctl.ienb ? r_dqm[0]       : 1'bz;
  assign DRAM_UDQM  = ctl.ienb ? r_dqm[DQM_W-1] : 1'bz;
  assign DRAM_DQ    = {DQ_W{1'bz}};
endmodule

// File: tb/tb_sdram_init_seq.sv
module tb_sdram_init_seq;
  logic iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Instance A: defaults (skip power-up on re-init). Instance B: short timing, full re-init.
  localparam int A_TP = 10000, A_TRP = 2, A_TRFC = 7, A_TMRD = 2, A_NREF = 8;
  localparam int B_TP = 4,     B_TRP = 2, B_TRFC = 3, B_TMRD = 2, B_NREF = 2;
  localparam int A_FIN = A_TP + A_TRP + A_NREF * A_TRFC + A_TMRD;
  localparam int B_FIN = B_TP + B_TRP + B_NREF * B_TRFC + B_TMRD;

  logic rstA, rstB;
  sdram_init_seq_if ifA();
  sdram_init_seq_if ifB();

  wire a_clk, a_cke, a_cs, a_ras, a_cas, a_we, a_ldqm, a_udqm;
  wire [12:0] a_addr; wire [1:0] a_ba; wire [15:0] unused_a_dq;
  wire b_clk, b_cke, b_cs, b_ras, b_cas, b_we, b_ldqm, b_udqm;
  wire [12:0] b_addr; wire [1:0] b_ba; wire [15:0] unused_b_dq;

  sdram_init_seq uA (
    .iclk(iclk), .ireset(rstA), .ctl(ifA),
    .DRAM_CLK(a_clk), .DRAM_CKE(a_cke), .DRAM_ADDR(a_addr), .DRAM_BA(a_ba),
    .DRAM_CS_N(a_cs), .DRAM_RAS_N(a_ras), .DRAM_CAS_N(a_cas), .DRAM_WE_N(a_we),
    .DRAM_LDQM(a_ldqm), .DRAM_UDQM(a_udqm), .DRAM_DQ(unused_a_dq));

  sdram_init_seq #(.T_POWERUP(B_TP), .N_REFRESH(B_NREF), .T_RFC(B_TRFC), .CAS_LAT(3),
                   .REINIT_SKIP_PWRUP(0)) uB (
    .iclk(iclk), .ireset(rstB), .ctl(ifB),
    .DRAM_CLK(b_clk), .DRAM_CKE(b_cke), .DRAM_ADDR(b_addr), .DRAM_BA(b_ba),
    .DRAM_CS_N(b_cs), .DRAM_RAS_N(b_ras), .DRAM_CAS_N(b_cas), .DRAM_WE_N(b_we),
    .DRAM_LDQM(b_ldqm), .DRAM_UDQM(b_udqm), .DRAM_DQ(unused_b_dq));

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- specification model ----------------
  function automatic logic [12:0] mw(input int cas, input int bt, input int bl, input int wb);
    return 13'((wb << 9) | (cas << 4) | (bt << 3) | bl);
  endfunction

  // Command expected n cycles after the start of a sequence.
  function automatic logic [3:0] exp_cmd(input longint n, input int tp, input int trp,
                                         input int trfc, input int nref);
    if (n == tp) return 4'b0010;
    for (int k = 0; k < nref; k++) if (n == tp + trp + k * trfc) return 4'b0001;
    if (n == tp + trp + nref * trfc) return 4'b0000;
    return 4'b0111;
  endfunction

  function automatic logic [12:0] exp_addr(input logic [3:0] c, input logic [12:0] mode);
    if (c == 4'b0010) return 13'h0400;
    if (c == 4'b0000) return mode;
    return 13'h0000;
  endfunction

  longint cyc = 0;
  bit     actA = 0, actB = 0;
  longint baseA = 0, baseB = 0;

  // base = cycle number at which "cycle 0" of the current sequence began.
  always @(posedge iclk) begin
    cyc = cyc + 1;
    if (rstA) actA = 0;
    else if (ifA.ireq) begin
      if (!actA) begin actA = 1; baseA = cyc; end
      else if (cyc - 1 - baseA >= A_FIN) baseA = cyc - A_TP;  // skip power-up
    end
    if (rstB) actB = 0;
    else if (ifB.ireq) begin
      if (!actB) begin actB = 1; baseB = cyc; end
      else if (cyc - 1 - baseB >= B_FIN) baseB = cyc;         // full redo
    end
  end

  // ---------------- compare process ----------------
  typedef struct { logic [3:0] cmd; logic [12:0] addr; longint rel; } ev_t;
  ev_t    evA[$], evB[$];
  bit     chkA = 0, chkB = 0, logA = 0, logB = 0, pfA = 0, pfB = 0;
  longint t0A = 0, t0B = 0, finA = -1, finB = -1;

  always @(negedge iclk) begin
    longint n; logic [3:0] ec; logic ef, eb;
    #1;
    if (chkA) begin
      n  = cyc - baseA;
      ec = actA ? exp_cmd(n, A_TP, A_TRP, A_TRFC, A_NREF) : 4'b0111;
      ef = actA && (n >= A_FIN);
      eb = actA && (n <  A_FIN);
      if (ifA.ienb)
        chk("A.pins", {a_clk, a_cke, a_cs, a_ras, a_cas, a_we, a_addr, a_ba, a_ldqm, a_udqm},
                      {1'b1, 1'b1, ec, exp_addr(ec, mw(2, 0, 0, 1)), 2'b00, 1'b1, 1'b1});
      chk("A.fin_busy", {ifA.ofin, ifA.obusy}, {ef, eb});
      if (logA && ifA.ienb && {a_cs, a_ras, a_cas, a_we} != 4'b0111)
        evA.push_back('{{a_cs, a_ras, a_cas, a_we}, a_addr, cyc - t0A});
      if (logA && ifA.ofin && !pfA) finA = cyc - t0A;
      pfA = ifA.ofin;
    end
    if (chkB) begin
      n  = cyc - baseB;
      ec = actB ? exp_cmd(n, B_TP, B_TRP, B_TRFC, B_NREF) : 4'b0111;
      ef = actB && (n >= B_FIN);
      eb = actB && (n <  B_FIN);
      if (ifB.ienb)
        chk("B.pins", {b_clk, b_cke, b_cs, b_ras, b_cas, b_we, b_addr, b_ba, b_ldqm, b_udqm},
                      {1'b1, 1'b1, ec, exp_addr(ec, mw(3, 0, 0, 1)), 2'b00, 1'b1, 1'b1});
      chk("B.fin_busy", {ifB.ofin, ifB.obusy}, {ef, eb});
      if (logB && ifB.ienb && {b_cs, b_ras, b_cas, b_we} != 4'b0111)
        evB.push_back('{{b_cs, b_ras, b_cas, b_we}, b_addr, cyc - t0B});
      if (logB && ifB.ofin && !pfB) finB = cyc - t0B;
      pfB = ifB.ofin;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge iclk); #2; end
  endtask

  task automatic wait_until(input longint t);
    while (cyc < t) step(1);
  endtask

  task automatic pulseA();
    ifA.ireq = 1'b1; t0A = cyc + 1; step(1); ifA.ireq = 1'b0;
  endtask

  task automatic pulseB();
    ifB.ireq = 1'b1; t0B = cyc + 1; step(1); ifB.ireq = 1'b0;
  endtask

  task automatic resetA();
    rstA = 1'b1; step(2); rstA = 1'b0;
  endtask

  bit doneB = 0;

  initial begin : stimB
    rstB = 1'b1; ifB.ireq = 1'b0; ifB.ienb = 1'b1;
    step(1); chkB = 1; step(1); rstB = 1'b0;
    // short sequence with hand-computed times
    logB = 1; evB.delete(); finB = -1; pulseB(); step(20); logB = 0;
    chk("B.nev", evB.size(), 4);
    if (evB.size() == 4) begin
      chk("B.pre_t",  evB[0].rel, 4);  chk("B.pre_c",  evB[0].cmd, 4'b0010);
      chk("B.ref0_t", evB[1].rel, 6);  chk("B.ref1_t", evB[2].rel, 9);
      chk("B.lmr_t",  evB[3].rel, 12); chk("B.lmr_a",  evB[3].addr, 13'h0230);
    end
    chk("B.fin_t", finB, 14);
    // re-init without skip: full power-up wait again
    logB = 1; evB.delete(); finB = -1; pulseB(); step(20); logB = 0;
    chk("B.re_pre_t", (evB.size() > 0) ? evB[0].rel : -1, 4);
    chk("B.re_fin_t", finB, 14);
    // reset mid-refresh, then restart
    rstB = 1'b1; step(1); rstB = 1'b0;
    pulseB(); wait_until(t0B + 7); rstB = 1'b1; step(1); rstB = 1'b0;
    chk("B.rst_busy", ifB.obusy, 1'b0);
    pulseB(); step(20);
    doneB = 1;
  end

  initial begin : stimA
    rstA = 1'b1; ifA.ireq = 1'b1; ifA.ienb = 1'b1;   // reset and request together
    step(1); chkA = 1; step(2);
    ifA.ireq = 1'b0; rstA = 1'b0; step(3);
    chk("A.rst_fin",  ifA.ofin, 1'b0);
    chk("A.rst_busy", ifA.obusy, 1'b0);
    chk("A.rst_cmd",  {a_cs, a_ras, a_cas, a_we}, 4'b0111);
    chk("A.rst_addr", a_addr, 13'h0);

    // run 1: default timing, pinned to literal times
    logA = 1; evA.delete(); finA = -1; pulseA(); wait_until(t0A + 10065); logA = 0;
    chk("A.nev", evA.size(), 10);
    if (evA.size() == 10) begin
      chk("A.pre_t", evA[0].rel, 10000); chk("A.pre_a", evA[0].addr, 13'h0400);
      for (int k = 0; k < 8; k++) begin
        chk($sformatf("A.ref%0d_t", k), evA[k + 1].rel, 10002 + 7 * k);
        chk($sformatf("A.ref%0d_c", k), evA[k + 1].cmd, 4'b0001);
      end
      chk("A.lmr_t", evA[9].rel, 10058); chk("A.lmr_a", evA[9].addr, 13'h0220);
      chk("A.lmr_c", evA[9].cmd, 4'b0000);
    end
    chk("A.fin_t", finA, 10060);

    // re-init from DONE: PRE on the next cycle, ofin 61 after the request cycle
    logA = 1; evA.delete(); finA = -1; pulseA(); wait_until(t0A + 70); logA = 0;
    chk("A.re_pre_t", (evA.size() > 0) ? evA[0].rel : -1, 0);
    chk("A.re_fin_t", finA, 60);

    // reset at cycle 10005, then a fresh sequence
    resetA(); pulseA(); wait_until(t0A + 10005);
    rstA = 1'b1; step(1); rstA = 1'b0;
    chk("A.mid_busy", ifA.obusy, 1'b0);
    chk("A.mid_fin",  ifA.ofin, 1'b0);
    logA = 1; evA.delete(); finA = -1; pulseA(); wait_until(t0A + 10065); logA = 0;
    chk("A.mid_fin_t", finA, 10060);

    // pins disabled, with a burst of enable toggling during the refreshes
    resetA(); ifA.ienb = 1'b0;
    logA = 1; finA = -1; pulseA();
    wait_until(t0A + 10010);
    for (int i = 0; i < 14; i++) begin ifA.ienb = ~ifA.ienb; step(3); end
    ifA.ienb = 1'b0; wait_until(t0A + 10065); logA = 0;
    chk("A.noenb_fin_t", finA, 10060);
    ifA.ienb = 1'b1;

    // request held high from IDLE: exactly one sequence
    resetA(); logA = 1; evA.delete(); finA = -1;
    ifA.ireq = 1'b1; t0A = cyc + 1; step(1);
    for (int i = 0; i < 11000 && !ifA.ofin; i++) step(1);
    ifA.ireq = 1'b0;
    chk("A.held_seen_fin", ifA.ofin, 1'b1);
    step(10); logA = 0;
    chk("A.held_fin_t", finA, 10060);
    chk("A.held_nev", evA.size(), 10);
    chk("A.held_stay", {ifA.ofin, ifA.obusy}, 2'b10);

    for (int i = 0; i < 200 && !doneB; i++) step(1);
    chk("B.finished", doneB, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
